// File: rtl/gobou_ctrl_emit.sv
// gobou_ctrl_emit: layer sequencer for the gobou (fully connected) datapath.
// One accepted req runs total_out neurons of total_in accumulate cycles each,
// emitting begin/valid/end strobes plus input, weight and output addresses.
// Optional macro GOBOU_EMIT_BIAS_EN inserts a one-cycle BIAS state per neuron
// (bias_oe strobe); without it bias_oe is tied to 0.
// Every output is a flop loaded from the next-state decode, so no input
// reaches an output combinationally.
module gobou_ctrl_emit #(
   parameter int CWIDTH = 12,
   parameter int WWIDTH = 20
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              req,
   input  logic [CWIDTH-1:0] total_in,
   input  logic [CWIDTH-1:0] total_out,
   output logic              busy,
   output logic              out_begin,
   output logic              out_valid,
   output logic              out_end,
   output logic              acc_en,
   output logic [CWIDTH-1:0] in_addr,
   output logic [WWIDTH-1:0] w_addr,
   output logic [CWIDTH-1:0] out_addr,
   output logic              bias_oe
);

   localparam logic [CWIDTH-1:0] C_ONE = CWIDTH'(1);
   localparam logic [WWIDTH-1:0] W_ONE = WWIDTH'(1);

   // S_BIAS is only reachable when the bias stage is compiled in.
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_WB} state_t;

   state_t            state_q, state_d;
   logic [CWIDTH-1:0] tin_m1_q, tin_m1_d;    // latched total_in - 1
   logic [CWIDTH-1:0] tout_m1_q, tout_m1_d;  // latched total_out - 1
   logic [CWIDTH-1:0] i_q, i_d;              // input index within neuron
   logic [CWIDTH-1:0] n_q, n_d;              // neuron index
   logic [WWIDTH-1:0] w_q, w_d;              // running weight address

   logic busy_d, out_begin_d, out_valid_d, out_end_d, acc_en_d;

   // Next-state, counter and next-output decode.
   // Indices are compared against count-1, so a width-max count never needs
   // a value wider than CWIDTH and i/n never wrap inside a layer.
   always_comb begin
      state_d   = state_q;
      tin_m1_d  = tin_m1_q;
      tout_m1_d = tout_m1_q;
      i_d       = i_q;
      n_d       = n_q;
      w_d       = w_q;
      case (state_q)
         S_IDLE: begin
            if (req && (total_in != '0) && (total_out != '0)) begin
               tin_m1_d  = total_in - C_ONE;
               tout_m1_d = total_out - C_ONE;
               i_d       = '0;
               n_d       = '0;
               w_d       = '0;
               state_d   = S_ACC;
            end
         end
         S_ACC: begin
            // Weight address runs continuously across neurons.
            w_d = w_q + W_ONE;
            if (i_q == tin_m1_q) begin
               i_d = '0;
`ifdef GOBOU_EMIT_BIAS_EN
               state_d = S_BIAS;
`else
               state_d = S_WB;
`endif
            end else begin
               i_d = i_q + C_ONE;
            end
         end
         S_BIAS: state_d = S_WB;
         S_WB: begin
            if (n_q == tout_m1_q) begin
               state_d = S_IDLE;
            end else begin
               n_d     = n_q + C_ONE;
               state_d = S_ACC;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d      = (state_d != S_IDLE);
      acc_en_d    = (state_d == S_ACC);
      out_begin_d = (state_d == S_ACC) && (i_d == '0);
      out_valid_d = (state_d == S_WB);
      out_end_d   = (state_d == S_WB) && (n_d == tout_m1_d);
   end

   // State, counters and registered strobes; reset aborts any layer.
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         state_q   <= S_IDLE;
         tin_m1_q  <= '0;
         tout_m1_q <= '0;
         i_q       <= '0;
         n_q       <= '0;
         w_q       <= '0;
         busy      <= 1'b0;
         acc_en    <= 1'b0;
         out_begin <= 1'b0;
         out_valid <= 1'b0;
         out_end   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tin_m1_q  <= tin_m1_d;
         tout_m1_q <= tout_m1_d;
         i_q       <= i_d;
         n_q       <= n_d;
         w_q       <= w_d;
         busy      <= busy_d;
         acc_en    <= acc_en_d;
         out_begin <= out_begin_d;
         out_valid <= out_valid_d;
         out_end   <= out_end_d;
      end
   end

   // Address outputs come straight from the counter flops.
   assign in_addr  = i_q;
   assign w_addr   = w_q;
   assign out_addr = n_q;

`ifdef GOBOU_EMIT_BIAS_EN
   // Bias-add strobe, one cycle per neuron between ACC and WB.
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) bias_oe <= 1'b0;
      else      bias_oe <= (state_d == S_BIAS);
   end
`else
   assign bias_oe = 1'b0;
`endif

endmodule

// File: tb/tb_gobou_ctrl_emit.sv
// Directed bench for gobou_ctrl_emit (default build or GOBOU_EMIT_BIAS_EN).
module tb_gobou_ctrl_emit;
   localparam int CW = 12;
   localparam int WW = 20;
`ifdef GOBOU_EMIT_BIAS_EN
   localparam int BIAS = 1;
`else
   localparam int BIAS = 0;
`endif

   logic          clk = 1'b0;
   logic          xrst = 1'b1;
   logic          req = 1'b0;
   logic [CW-1:0] total_in = '0, total_out = '0;
   logic          busy, out_begin, out_valid, out_end, acc_en, bias_oe;
   logic [CW-1:0] in_addr, out_addr;
   logic [WW-1:0] w_addr;

   // Second instance with a narrow weight address for the wrap check.
   logic          req2 = 1'b0;
   logic [CW-1:0] tin2 = '0, tout2 = '0;
   logic          busy2, begin2, valid2, end2, acc2, bias2;
   logic [CW-1:0] in_addr2, out_addr2;
   logic [3:0]    w_addr2;

   int n_checks = 0;
   int n_fail   = 0;

   gobou_ctrl_emit #(.CWIDTH(CW), .WWIDTH(WW)) dut (
      .clk(clk), .xrst(xrst), .req(req), .total_in(total_in), .total_out(total_out),
      .busy(busy), .out_begin(out_begin), .out_valid(out_valid), .out_end(out_end),
      .acc_en(acc_en), .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr),
      .bias_oe(bias_oe));

   gobou_ctrl_emit #(.CWIDTH(CW), .WWIDTH(4)) dut_w4 (
      .clk(clk), .xrst(xrst), .req(req2), .total_in(tin2), .total_out(tout2),
      .busy(busy2), .out_begin(begin2), .out_valid(valid2), .out_end(end2),
      .acc_en(acc2), .in_addr(in_addr2), .w_addr(w_addr2), .out_addr(out_addr2),
      .bias_oe(bias2));

   always #5 clk = ~clk;

   // Expected 3x2 timeline, one entry per cycle from c1.
   // Flags are {busy, acc_en, out_begin, out_valid, out_end, bias_oe}.
`ifdef GOBOU_EMIT_BIAS_EN
   localparam int N32 = 11;
   localparam logic [5:0] EF [N32] = '{6'b111000, 6'b110000, 6'b110000, 6'b100001,
      6'b100100, 6'b111000, 6'b110000, 6'b110000, 6'b100001, 6'b100110, 6'b000000};
   localparam int EI [N32] = '{0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0};
   localparam int EW [N32] = '{0, 1, 2, 0, 0, 3, 4, 5, 0, 0, 0};
   localparam int EO [N32] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   localparam int NS = 4;
   localparam logic [5:0] ES [NS] = '{6'b111000, 6'b100001, 6'b100110, 6'b000000};
`else
   localparam int N32 = 9;
   localparam logic [5:0] EF [N32] = '{6'b111000, 6'b110000, 6'b110000, 6'b100100,
      6'b111000, 6'b110000, 6'b110000, 6'b100110, 6'b000000};
   localparam int EI [N32] = '{0, 1, 2, 0, 0, 1, 2, 0, 0};
   localparam int EW [N32] = '{0, 1, 2, 0, 3, 4, 5, 0, 0};
   localparam int EO [N32] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
   localparam int NS = 3;
   localparam logic [5:0] ES [NS] = '{6'b111000, 6'b100110, 6'b000000};
`endif

   function automatic logic [5:0] flags();
      return {busy, acc_en, out_begin, out_valid, out_end, bias_oe};
   endfunction

   // Drives req for one cycle; returns at the falling edge inside c1.
   task automatic pulse_req(input logic [CW-1:0] ti, input logic [CW-1:0] to);
      @(negedge clk);
      total_in = ti; total_out = to; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      for (k = 0; k < 40 && busy; k++) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL %s idle timeout: busy=%b required 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (flags() !== 6'b0 || in_addr !== '0 || w_addr !== '0 || out_addr !== '0) begin
         n_fail++;
         $display("FAIL reset: flags=%b in=%0d w=%0d out=%0d required all 0",
                  flags(), in_addr, w_addr, out_addr);
      end
      @(negedge clk); xrst = 1'b0;
   endtask

   task automatic run_3x2(input bit inject, input string tag);
      pulse_req(3, 2);
      for (int k = 0; k < N32; k++) begin
         n_checks++;
         if (flags() !== EF[k]) begin
            n_fail++; $display("FAIL %s flags c%0d: got %b required %b", tag, k+1, flags(), EF[k]);
         end
         if (EF[k][4]) begin
            n_checks++;
            if (in_addr !== CW'(EI[k]) || w_addr !== WW'(EW[k])) begin
               n_fail++;
               $display("FAIL %s addr c%0d: in=%0d w=%0d required in=%0d w=%0d",
                        tag, k+1, in_addr, w_addr, EI[k], EW[k]);
            end
         end
         if (EF[k][2]) begin
            n_checks++;
            if (out_addr !== CW'(EO[k])) begin
               n_fail++; $display("FAIL %s out_addr c%0d: got %0d required %0d", tag, k+1, out_addr, EO[k]);
            end
         end
         if (inject && k == 1) begin
            req = 1'b1; total_in = 5; total_out = 7;
         end
         @(negedge clk);
         req = 1'b0;
      end
   endtask

   task automatic test_single();
      pulse_req(1, 1);
      for (int k = 0; k < NS; k++) begin
         n_checks++;
         if (flags() !== ES[k]) begin
            n_fail++; $display("FAIL single flags c%0d: got %b required %b", k+1, flags(), ES[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_zero_count();
      pulse_req(0, 2);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (flags() !== 6'b0) begin
            n_fail++; $display("FAIL zero_in c%0d: flags=%b required 000000", k+1, flags());
         end
         @(negedge clk);
      end
      pulse_req(3, 0);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (flags() !== 6'b0) begin
            n_fail++; $display("FAIL zero_out c%0d: flags=%b required 000000", k+1, flags());
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      pulse_req(3, 2);
      @(negedge clk); @(negedge clk);   // c3
      n_checks++;
      if (acc_en !== 1'b1 || w_addr !== WW'(2)) begin
         n_fail++; $display("FAIL rmid pre c3: acc=%b w=%0d required acc=1 w=2", acc_en, w_addr);
      end
      xrst = 1'b1;
      #1;
      n_checks++;
      if (flags() !== 6'b0 || in_addr !== '0 || w_addr !== '0 || out_addr !== '0) begin
         n_fail++;
         $display("FAIL rmid async: flags=%b in=%0d w=%0d required all 0", flags(), in_addr, w_addr);
      end
      @(negedge clk); xrst = 1'b0;
      pulse_req(3, 2);
      n_checks++;
      if (out_begin !== 1'b1 || in_addr !== '0 || w_addr !== '0) begin
         n_fail++;
         $display("FAIL rmid restart c1: begin=%b in=%0d w=%0d required 1/0/0", out_begin, in_addr, w_addr);
      end
      @(negedge clk);
      n_checks++;
      if (in_addr !== CW'(1) || w_addr !== WW'(1)) begin
         n_fail++; $display("FAIL rmid restart c2: in=%0d w=%0d required 1/1", in_addr, w_addr);
      end
      wait_idle("rmid");
   endtask

   task automatic test_back_to_back();
      bit seen;
      seen = 1'b0;
      pulse_req(1, 1);
      for (int k = 0; k < 10; k++) begin
         if (out_end) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL b2b out_end timeout: seen=0 required 1");
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b gap busy: got %b required 0", busy);
      end
      total_in = 1; total_out = 1; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      n_checks++;
      if (out_begin !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL b2b restart: begin=%b busy=%b required 1/1", out_begin, busy);
      end
      wait_idle("b2b");
   endtask

   task automatic test_wrap();
      int acc_n, val_n, busy_n;
      bit done;
      acc_n = 0; val_n = 0; busy_n = 0; done = 1'b0;
      @(negedge clk);
      tin2 = 5; tout2 = 4; req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (busy2) busy_n++;
         if (acc2) begin
            acc_n++;
            if (acc_n == 16 || acc_n == 17) begin
               n_checks++;
               if (w_addr2 !== ((acc_n == 16) ? 4'd15 : 4'd0)) begin
                  n_fail++; $display("FAIL wrap w_addr acc#%0d: got %0d", acc_n, w_addr2);
               end
            end
         end
         if (valid2) begin
            val_n++;
            n_checks++;
            if (end2 !== (val_n == 4)) begin
               n_fail++; $display("FAIL wrap out_end valid#%0d: got %b required %b", val_n, end2, val_n == 4);
            end
         end
         if (end2) begin done = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!done || acc_n != 20 || busy_n != 4 * (5 + 1 + BIAS)) begin
         n_fail++;
         $display("FAIL wrap totals: done=%b acc=%0d busy=%0d required 1/20/%0d",
                  done, acc_n, busy_n, 4 * (5 + 1 + BIAS));
      end
   endtask

   initial begin
      test_reset();
      run_3x2(1'b0, "layer");
      run_3x2(1'b1, "ignored_req");
      test_single();
      test_zero_count();
      test_reset_mid();
      test_back_to_back();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/gobou_ctrl_emit.md
# gobou_ctrl_emit

Layer sequencer for the gobou (fully connected) datapath. It generates the begin/valid/end control stream consumed by the downstream gobou pipeline stages (accumulate, bias, ReLU, write-back), together with input, weight and output addresses. One `req` pulse runs one complete layer of `total_out` neurons, each accumulating `total_in` inputs.

## Interface
Parameters:
- `CWIDTH`, 12: width of neuron/input counters and of `in_addr`/`out_addr`.
- `WWIDTH`, 20: width of the running weight address `w_addr`.

Ports:
- `clk` input 1: single clock, rising edge.
- `xrst` input 1: reset, asynchronous, active-high.
- `req` input 1: one-cycle start pulse; sampled only in IDLE.
- `total_in` input CWIDTH: inputs per neuron; latched on an accepted `req`.
- `total_out` input CWIDTH: neurons per layer; latched on an accepted `req`.
- `busy` output 1: high from the first ACC cycle through the cycle carrying `out_end`.
- `out_begin` output 1: pulse on the first accumulate cycle of each neuron (accumulator clear).
- `out_valid` output 1: pulse when a neuron's result is complete.
- `out_end` output 1: pulse coincident with the last `out_valid` of the layer.
- `acc_en` output 1: high on every accumulate cycle.
- `in_addr` output CWIDTH: input feature index, 0..total_in-1.
- `w_addr` output WWIDTH: weight address = neuron*total_in + input index, mod 2^WWIDTH.
- `out_addr` output CWIDTH: neuron index, valid while `out_valid`=1.
- `bias_oe` output 1: bias-add strobe (see Configuration).

## Operation
- FSM states: IDLE, ACC, BIAS (macro only), WB.
- IDLE: `req`=1 with `total_in`≠0 and `total_out`≠0 → latch counts, clear counters → ACC. A `req` with either count 0 is ignored: no outputs toggle and the FSM stays in IDLE.
- ACC: `acc_en`=1, `in_addr`=i, `w_addr` increments by 1 each cycle and is never reset between neurons. `out_begin`=1 when i=0. After i=total_in-1 → BIAS if compiled in, else WB.
- BIAS: one cycle with `bias_oe`=1, `acc_en`=0 → WB.
- WB: one cycle with `out_valid`=1 and `out_addr`=n. If n=total_out-1: `out_end`=1 → IDLE. Otherwise n+1 → ACC.
- `req` during `busy` is ignored, and latched counts do not change mid-layer.
- All outputs are registered (FSM-state decoded through flops), so no combinational path exists from input to output.
- Counters compare against the latched count minus 1. Width-max counts (2^CWIDTH-1) are legal and must not overflow.

## Timing
- Reset: every output is 0 immediately on `xrst`=1 (asynchronous), and the FSM is in IDLE. Asserting `xrst` mid-layer aborts the layer; the next accepted `req` starts from index 0 with `w_addr`=0.
- `req` at cycle c → first ACC cycle (`out_begin`, `busy`) at c+1.
- Cycles per neuron: total_in+1, or total_in+2 with bias.
- Layer length: total_out*(total_in+1) cycles of `busy`. `busy`=0 on the cycle after `out_end`.
- A new `req` is accepted in the first IDLE cycle after `out_end`, giving back-to-back layers with a 1-cycle gap.
- `out_begin` and `out_valid` are never high in the same cycle. `out_end` is high only together with `out_valid`.

## Configuration
- `GOBOU_EMIT_BIAS_EN`:
  - Defined: the BIAS state is inserted after each neuron's ACC phase. `bias_oe` pulses there, and `out_valid` moves one cycle later.
  - Undefined: the BIAS state is absent and `bias_oe` is constant 0.

## Test plan
- Layer without bias: reset; `req` at c0 with total_in=3, total_out=2. Required response:
  - `out_begin` at c1 and c5.
  - `in_addr` 0,1,2 at c1–c3 and again at c5–c7.
  - `w_addr` 0–5 across the ACC cycles.
  - `out_valid` at c4 (`out_addr`=0) and at c8 (`out_addr`=1, `out_end`=1).
  - `busy`=1 at c1–c8 and 0 at c9.
- Same stimulus with `GOBOU_EMIT_BIAS_EN`: `bias_oe` at c4 and c9, `out_valid` at c5 and c10, `out_end` at c10.
- Single-element layer: total_in=1, total_out=1 → `out_begin`+`acc_en` at c1; `out_valid`+`out_end` at c2.
- Ignored requests:
  - `req` pulsed at c2 during the first scenario → the timeline is unchanged.
  - `req` with total_in=0 → `busy` stays 0 and no strobes are emitted.
- Reset mid-layer: `xrst` asserted at c3 of the first scenario → all outputs 0 in the same cycle. A new `req` then restarts with `in_addr`=0 and `w_addr`=0.
- Weight-address wrap: `WWIDTH`=4, total_in=5, total_out=4 → `w_addr` wraps 15→0 on the 17th accumulate cycle, and `out_end` follows the fourth `out_valid`.
